// File: rtl/ldm_stm_seq_pkg.sv
// Shared definitions for the LDM/STM sequencer: FSM encoding, PC index,
// default transfer stride and the P/U addressing-mode encoding.
package ldm_stm_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [3:0] PC_IDX = 4'd15;

    localparam int unsigned WORD_BYTES = 4;

    // Encoded as {~U, P}.
    typedef enum logic [1:0] {
        AM_IA = 2'd0,
        AM_IB = 2'd1,
        AM_DA = 2'd2,
        AM_DB = 2'd3
    } am_mode_e;

endpackage

// File: rtl/ldm_stm_seq_reg_list_scan.sv
// Picks the lowest set register in a remaining-transfer mask and reports
// whether it is the last one, plus the mask with that bit removed.
module reg_list_scan (
    input  logic [15:0] mask,
    output logic [3:0]  idx,
    output logic        last,
    output logic [15:0] rest
);

    always_comb begin
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) idx = 4'(i);
        end
    end

    assign rest = mask & (mask - 16'd1);
    assign last = (mask != 16'd0) && (rest == 16'd0);

endmodule

// File: rtl/ldm_stm_seq.sv
// Block load/store sequencer: walks the register list one word per mem_ack,
// drives register-file reads/writes and performs base writeback in WB.
module ldm_stm_seq #(
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic [15:0] reg_list,
    input  logic [31:0] base_addr,
    input  logic [3:0]  rn,
    input  logic        up,
    input  logic        pre,
    input  logic        wback,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  r_addr,
    input  logic [31:0] r_data,
    output logic [3:0]  w_addr,
    output logic [31:0] w_data,
    output logic        write_reg,
    output logic        write_pc,
    output logic [31:0] pc_data,
    output logic [1:0]  state_dbg
);

    import ldm_stm_seq_pkg::*;

    logic [1:0]  state;
    logic [15:0] mask_q;
    logic        is_load_q;
    logic        wback_q;
    logic        rn_in_list_q;
    logic        nonempty_q;
    logic [3:0]  rn_q;
    logic [31:0] final_q;

    logic [4:0]  n_regs;
    logic [31:0] span;
    logic [31:0] first_addr;
    logic [31:0] final_addr;
    am_mode_e    mode;

    logic [3:0]  cur_idx;
    logic        cur_last;
    logic [15:0] mask_rest;
    logic        xfer_ack;

    always_comb begin
        n_regs = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n_regs = n_regs + 5'(reg_list[i]);
        end
    end

    assign span = 32'(n_regs) * 32'(WORD_BYTES);
    assign mode = am_mode_e'({~up, pre});

    always_comb begin
        first_addr = base_addr;
        case (mode)
            AM_IA:   first_addr = base_addr;
            AM_IB:   first_addr = base_addr + 32'(WORD_BYTES);
            AM_DA:   first_addr = base_addr - span + 32'(WORD_BYTES);
            AM_DB:   first_addr = base_addr - span;
            default: first_addr = base_addr;
        endcase
    end

    assign final_addr = up ? (base_addr + span) : (base_addr - span);

    reg_list_scan u_scan (
        .mask (mask_q),
        .idx  (cur_idx),
        .last (cur_last),
        .rest (mask_rest)
    );

    assign xfer_ack = (state == ST_XFER) && mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= 32'd0;
            mask_q       <= 16'd0;
            is_load_q    <= 1'b0;
            wback_q      <= 1'b0;
            rn_in_list_q <= 1'b0;
            nonempty_q   <= 1'b0;
            rn_q         <= 4'd0;
            final_q      <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        is_load_q    <= is_load;
                        wback_q      <= wback;
                        rn_q         <= rn;
                        rn_in_list_q <= reg_list[rn];
                        nonempty_q   <= |reg_list;
                        final_q      <= final_addr;
                        mask_q       <= reg_list;
                        busy         <= 1'b1;
                        if (|reg_list) begin
                            state    <= ST_XFER;
                            mem_req  <= 1'b1;
                            mem_addr <= {first_addr[31:2], 2'b00};
                        end else begin
                            state <= ST_WB;
                        end
                    end
                end
                ST_XFER: begin
                    if (mem_ack) begin
                        mask_q   <= mask_rest;
                        mem_addr <= mem_addr + 32'(WORD_BYTES);
                        if (cur_last) begin
                            state    <= ST_WB;
                            mem_req  <= 1'b0;
                            mem_addr <= 32'd0;
                        end
                    end
                end
                ST_WB: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;
    assign done      = (state == ST_WB);
    assign mem_we    = mem_req && !is_load_q;
    assign r_addr    = (state == ST_XFER) ? cur_idx : 4'd0;
    assign mem_wdata = (state == ST_XFER) ? r_data : 32'd0;

    // A loaded Rn takes priority over the written-back base.
    always_comb begin
        write_reg = 1'b0;
        write_pc  = 1'b0;
        w_addr    = 4'd0;
        w_data    = 32'd0;
        pc_data   = 32'd0;
        if (xfer_ack && is_load_q) begin
            if (cur_idx == PC_IDX) begin
                write_pc = 1'b1;
                pc_data  = {mem_rdata[31:2], 2'b00};
            end else begin
                write_reg = 1'b1;
                w_addr    = cur_idx;
                w_data    = mem_rdata;
            end
        end else if ((state == ST_WB) && wback_q && nonempty_q &&
                     !(is_load_q && rn_in_list_q) && (rn_q != PC_IDX)) begin
            write_reg = 1'b1;
            w_addr    = rn_q;
            w_data    = final_q;
        end
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Bench for ldm_stm_seq: directed scenarios plus randomized block transfers
// compared against a list-level reference model of the expected accesses.
module tb_ldm_stm_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic [15:0] reg_list = 16'd0;
    logic [31:0] base_addr = 32'd0;
    logic [3:0]  rn = 4'd0;
    logic        up = 1'b0;
    logic        pre = 1'b0;
    logic        wback = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy, done, mem_req, mem_we, write_reg, write_pc;
    logic [31:0] mem_addr, mem_wdata, w_data, pc_data, r_data;
    logic [3:0]  r_addr, w_addr;
    logic [1:0]  state_dbg;

    logic [31:0] regs [16];
    logic [31:0] mem_img [logic [31:0]];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  idx;
        logic        we;
        logic [31:0] wdata;
        int          hold;
    } mem_ev_t;

    typedef struct {
        logic        pc;
        logic [3:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_ev_t;

    mem_ev_t obs_mem[$];
    mem_ev_t exp_mem[$];
    wr_ev_t  obs_wr[$];
    wr_ev_t  exp_wr[$];

    int n_checks = 0;
    int n_errors = 0;
    int done_cycle, done_cnt, busy_bad, unstable, req_cycles, dly_sum;

    assign r_data = regs[r_addr];

    always #5 clk = ~clk;

    ldm_stm_seq #(.WORD_BYTES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load),
        .reg_list(reg_list), .base_addr(base_addr), .rn(rn),
        .up(up), .pre(pre), .wback(wback),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .r_addr(r_addr), .r_data(r_data),
        .w_addr(w_addr), .w_data(w_data), .write_reg(write_reg),
        .write_pc(write_pc), .pc_data(pc_data), .state_dbg(state_dbg)
    );

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic fill_regs();
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
    endtask

    // Reference: list of word accesses and register writes implied by the instruction.
    task automatic model_op(input logic ld, input logic [15:0] list, input logic [31:0] base,
                            input logic [3:0] rnv, input logic u, input logic p, input logic w);
        int n;
        logic [31:0] a, fin, span;
        exp_mem.delete();
        exp_wr.delete();
        n = $countones(list);
        span = 32'(n * 4);
        fin = u ? base + span : base - span;
        if (u) a = p ? base + 32'd4 : base;
        else   a = p ? base - span : base - span + 32'd4;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                exp_mem.push_back('{a, 4'(i), !ld, regs[i], 0});
                if (ld && i == 15) exp_wr.push_back('{1'b1, 4'd15, mem_read(a) & 32'hFFFF_FFFC, 0});
                else if (ld)       exp_wr.push_back('{1'b0, 4'(i), mem_read(a), 0});
                a = a + 32'd4;
            end
        end
        if (w && n != 0 && !(ld && list[rnv]) && rnv != 4'd15)
            exp_wr.push_back('{1'b0, rnv, fin, 0});
    endtask

    // Issues one instruction, acts as memory, and records everything the DUT does.
    task automatic run_op(input logic ld, input logic [15:0] list, input logic [31:0] base,
                          input logic [3:0] rnv, input logic u, input logic p, input logic w,
                          input int dmin, input int dmax, input logic noise);
        int hold, dly;
        logic active;
        logic [31:0] h_addr;
        logic [3:0] h_idx;
        obs_mem.delete();
        obs_wr.delete();
        done_cycle = -1; done_cnt = 0; busy_bad = 0; unstable = 0; req_cycles = 0; dly_sum = 0;
        hold = 0; dly = 0; active = 1'b0; h_addr = '0; h_idx = '0;
        @(posedge clk); #1;
        start = 1'b1; is_load = ld; reg_list = list; base_addr = base; rn = rnv;
        up = u; pre = p; wback = w; mem_ack = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= 400; c++) begin
            if (noise && done_cycle < 0) begin
                start = 1'($urandom_range(1, 0));
                is_load = 1'($urandom_range(1, 0));
                reg_list = 16'($urandom);
                base_addr = $urandom;
                rn = 4'($urandom_range(15, 0));
                up = 1'($urandom_range(1, 0));
                pre = 1'($urandom_range(1, 0));
                wback = 1'($urandom_range(1, 0));
            end else begin
                start = 1'b0;
            end
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                if (!active) begin
                    active = 1'b1; hold = 0;
                    dly = int'($urandom_range(dmax, dmin));
                    h_addr = mem_addr; h_idx = r_addr;
                end else if (mem_addr !== h_addr || r_addr !== h_idx) begin
                    unstable++;
                end
                req_cycles++;
                if (hold == dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_read(mem_addr);
                end
            end
            #1;
            if (mem_ack) begin
                obs_mem.push_back('{mem_addr, r_addr, mem_we, mem_wdata, hold + 1});
                dly_sum += hold + 1;
                active = 1'b0;
            end else if (mem_req) begin
                hold++;
            end
            if (write_reg) obs_wr.push_back('{1'b0, w_addr, w_data, c});
            if (write_pc)  obs_wr.push_back('{1'b1, 4'd15, pc_data, c});
            if (done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (done_cycle < 0 || c == done_cycle) begin
                if (busy !== 1'b1) busy_bad++;
            end else begin
                if (busy !== 1'b0 || done !== 1'b0) busy_bad++;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({busy, done, mem_req, mem_we, mem_addr, mem_wdata, r_addr, w_addr, w_data,
             write_reg, write_pc, pc_data, state_dbg} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: busy=%b done=%b req=%b addr=%h wreg=%b wpc=%b state=%0d, required all 0",
                     busy, done, mem_req, mem_addr, write_reg, write_pc, state_dbg);
        end
        rst = 1'b0;
        @(posedge clk); #2;
        n_checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || state_dbg !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_idle: busy=%b req=%b state=%0d, required 0 0 0", busy, mem_req, state_dbg);
        end
    endtask

    task automatic test_ldmia_pc();
        fill_regs();
        mem_img[32'h1000] = 32'hA;
        mem_img[32'h1004] = 32'hB;
        mem_img[32'h1008] = 32'h2003;
        run_op(1'b1, 16'h8006, 32'h1000, 4'd0, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        n_checks++;
        if (obs_mem.size() != 3 || obs_wr.size() != 4) begin
            n_errors++;
            $display("FAIL ldmia_counts: mem=%0d wr=%0d, required 3 4", obs_mem.size(), obs_wr.size());
        end else begin
            n_checks++;
            if (obs_mem[0].addr !== 32'h1000 || obs_mem[1].addr !== 32'h1004 || obs_mem[2].addr !== 32'h1008) begin
                n_errors++;
                $display("FAIL ldmia_addr: %h %h %h, required 1000 1004 1008",
                         obs_mem[0].addr, obs_mem[1].addr, obs_mem[2].addr);
            end
            n_checks++;
            if (obs_wr[0] != '{1'b0, 4'd1, 32'hA, 1} || obs_wr[1] != '{1'b0, 4'd2, 32'hB, 2}) begin
                n_errors++;
                $display("FAIL ldmia_regs: r%0d=%h@%0d r%0d=%h@%0d, required r1=a@1 r2=b@2",
                         obs_wr[0].addr, obs_wr[0].data, obs_wr[0].cyc, obs_wr[1].addr, obs_wr[1].data, obs_wr[1].cyc);
            end
            n_checks++;
            if (obs_wr[2] != '{1'b1, 4'd15, 32'h2000, 3}) begin
                n_errors++;
                $display("FAIL ldmia_pc: pc=%b data=%h cyc=%0d, required pc write 2000 at 3",
                         obs_wr[2].pc, obs_wr[2].data, obs_wr[2].cyc);
            end
            n_checks++;
            if (obs_wr[3] != '{1'b0, 4'd0, 32'h100C, 4}) begin
                n_errors++;
                $display("FAIL ldmia_wb: r%0d=%h@%0d, required r0=100c@4", obs_wr[3].addr, obs_wr[3].data, obs_wr[3].cyc);
            end
        end
        n_checks++;
        if (done_cycle != 4 || busy_bad != 0) begin
            n_errors++;
            $display("FAIL ldmia_done: done_cycle=%0d busy_bad=%0d, required 4 0", done_cycle, busy_bad);
        end
    endtask

    task automatic test_stmdb();
        fill_regs();
        run_op(1'b0, 16'h4010, 32'h8000, 4'd13, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        n_checks++;
        if (obs_mem.size() != 2 || obs_wr.size() != 1) begin
            n_errors++;
            $display("FAIL stmdb_counts: mem=%0d wr=%0d, required 2 1", obs_mem.size(), obs_wr.size());
        end else begin
            n_checks++;
            if (obs_mem[0] != '{32'h7FF8, 4'd4, 1'b1, regs[4], 1} ||
                obs_mem[1] != '{32'h7FFC, 4'd14, 1'b1, regs[14], 1}) begin
                n_errors++;
                $display("FAIL stmdb_xfer: %h/r%0d/we%b/%h then %h/r%0d/we%b/%h, required 7ff8/r4/%h 7ffc/r14/%h",
                         obs_mem[0].addr, obs_mem[0].idx, obs_mem[0].we, obs_mem[0].wdata,
                         obs_mem[1].addr, obs_mem[1].idx, obs_mem[1].we, obs_mem[1].wdata, regs[4], regs[14]);
            end
            n_checks++;
            if (obs_wr[0] != '{1'b0, 4'd13, 32'h7FF8, 3}) begin
                n_errors++;
                $display("FAIL stmdb_wb: r%0d=%h@%0d, required r13=7ff8@3", obs_wr[0].addr, obs_wr[0].data, obs_wr[0].cyc);
            end
        end
    endtask

    task automatic test_ldmib_wrap();
        fill_regs();
        run_op(1'b1, 16'h0020, 32'hFFFF_FFFC, 4'd3, 1'b1, 1'b1, 1'b0, 3, 3, 1'b0);
        n_checks++;
        if (obs_mem.size() != 1 || obs_mem[0].addr !== 32'h0 || obs_mem[0].hold != 4 || unstable != 0) begin
            n_errors++;
            $display("FAIL ldmib_wrap_addr: n=%0d addr=%h hold=%0d unstable=%0d, required 1 00000000 4 0",
                     obs_mem.size(), obs_mem.size() > 0 ? obs_mem[0].addr : 32'hX,
                     obs_mem.size() > 0 ? obs_mem[0].hold : -1, unstable);
        end
        n_checks++;
        if (obs_wr.size() != 1 || obs_wr[0] != '{1'b0, 4'd5, mem_read(32'h0), 4}) begin
            n_errors++;
            $display("FAIL ldmib_wrap_write: count=%0d, required single r5=%h at 4", obs_wr.size(), mem_read(32'h0));
        end
        n_checks++;
        if (done_cycle != 5) begin
            n_errors++;
            $display("FAIL ldmib_wrap_done: done_cycle=%0d, required 5", done_cycle);
        end
    endtask

    task automatic test_base_in_list_and_empty();
        fill_regs();
        run_op(1'b1, 16'h000C, 32'h400, 4'd2, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        n_checks++;
        if (obs_wr.size() != 2 || obs_wr[0] != '{1'b0, 4'd2, mem_read(32'h400), 1} ||
            obs_wr[1] != '{1'b0, 4'd3, mem_read(32'h404), 2}) begin
            n_errors++;
            $display("FAIL base_in_list: writes=%0d, required r2=%h r3=%h and no writeback",
                     obs_wr.size(), mem_read(32'h400), mem_read(32'h404));
        end
        run_op(1'b1, 16'h0000, 32'h500, 4'd1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        n_checks++;
        if (done_cycle != 1 || req_cycles != 0 || obs_wr.size() != 0 || busy_bad != 0) begin
            n_errors++;
            $display("FAIL empty_list: done_cycle=%0d req=%0d writes=%0d busy_bad=%0d, required 1 0 0 0",
                     done_cycle, req_cycles, obs_wr.size(), busy_bad);
        end
    endtask

    task automatic test_reset_mid();
        fill_regs();
        @(posedge clk); #1;
        start = 1'b1; is_load = 1'b0; reg_list = 16'h00F0; base_addr = 32'h2000;
        rn = 4'd1; up = 1'b1; pre = 1'b0; wback = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mem_ack = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h2000 || r_addr !== 4'd4) begin
            n_errors++;
            $display("FAIL rstmid_first: req=%b addr=%h r_addr=%0d, required 1 2000 4", mem_req, mem_addr, r_addr);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (mem_addr !== 32'h2004 || r_addr !== 4'd5 || mem_wdata !== regs[5]) begin
            n_errors++;
            $display("FAIL rstmid_second: addr=%h r_addr=%0d wdata=%h, required 2004 5 %h",
                     mem_addr, r_addr, mem_wdata, regs[5]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, mem_req, mem_we, mem_addr, mem_wdata, r_addr, w_addr, w_data,
             write_reg, write_pc, pc_data, state_dbg} !== '0) begin
            n_errors++;
            $display("FAIL rstmid_zero: busy=%b req=%b addr=%h wdata=%h state=%0d, required all 0",
                     busy, mem_req, mem_addr, mem_wdata, state_dbg);
        end
        run_op(1'b1, 16'h0003, 32'h3000, 4'd7, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        n_checks++;
        if (obs_wr.size() != 3 || obs_wr[0] != '{1'b0, 4'd0, mem_read(32'h3000), 1} ||
            obs_wr[1] != '{1'b0, 4'd1, mem_read(32'h3004), 2} || obs_wr[2] != '{1'b0, 4'd7, 32'h3008, 3}) begin
            n_errors++;
            $display("FAIL rstmid_restart: writes=%0d done_cycle=%0d, required r0 r1 r7=3008 with done at 3",
                     obs_wr.size(), done_cycle);
        end
    endtask

    task automatic test_random();
        logic        ld, u, p, w;
        logic [15:0] list;
        logic [31:0] base;
        logic [3:0]  rnv;
        for (int t = 0; t < 30; t++) begin
            fill_regs();
            ld = 1'($urandom_range(1, 0));
            u = 1'($urandom_range(1, 0));
            p = 1'($urandom_range(1, 0));
            w = 1'($urandom_range(1, 0));
            list = ($urandom_range(5, 0) == 0) ? 16'd0 : 16'($urandom);
            base = $urandom & 32'hFFFF_FFFC;
            rnv = 4'($urandom_range(15, 0));
            model_op(ld, list, base, rnv, u, p, w);
            run_op(ld, list, base, rnv, u, p, w, 0, 2, 1'b1);
            n_checks++;
            if (obs_mem.size() != exp_mem.size() || obs_wr.size() != exp_wr.size()) begin
                n_errors++;
                $display("FAIL rand_counts[%0d]: mem=%0d wr=%0d, required %0d %0d",
                         t, obs_mem.size(), obs_wr.size(), exp_mem.size(), exp_wr.size());
            end
            for (int k = 0; k < exp_mem.size() && k < obs_mem.size(); k++) begin
                n_checks++;
                if (obs_mem[k].addr !== exp_mem[k].addr || obs_mem[k].idx !== exp_mem[k].idx ||
                    obs_mem[k].we !== exp_mem[k].we || obs_mem[k].wdata !== exp_mem[k].wdata) begin
                    n_errors++;
                    $display("FAIL rand_mem[%0d.%0d]: got %h r%0d we%b %h, required %h r%0d we%b %h", t, k,
                             obs_mem[k].addr, obs_mem[k].idx, obs_mem[k].we, obs_mem[k].wdata,
                             exp_mem[k].addr, exp_mem[k].idx, exp_mem[k].we, exp_mem[k].wdata);
                end
            end
            for (int k = 0; k < exp_wr.size() && k < obs_wr.size(); k++) begin
                n_checks++;
                if (obs_wr[k].pc !== exp_wr[k].pc || obs_wr[k].addr !== exp_wr[k].addr ||
                    obs_wr[k].data !== exp_wr[k].data) begin
                    n_errors++;
                    $display("FAIL rand_wr[%0d.%0d]: got pc%b r%0d %h, required pc%b r%0d %h", t, k,
                             obs_wr[k].pc, obs_wr[k].addr, obs_wr[k].data,
                             exp_wr[k].pc, exp_wr[k].addr, exp_wr[k].data);
                end
            end
            n_checks++;
            if (done_cycle != 1 + dly_sum || done_cnt != 1 || busy_bad != 0 || unstable != 0) begin
                n_errors++;
                $display("FAIL rand_timing[%0d]: done_cycle=%0d done_cnt=%0d busy_bad=%0d unstable=%0d, required %0d 1 0 0",
                         t, done_cycle, done_cnt, busy_bad, unstable, 1 + dly_sum);
            end
        end
    endtask

    initial begin
        fill_regs();
        test_reset();
        test_ldmia_pc();
        test_stmdb();
        test_ldmib_wrap();
        test_base_in_list_and_empty();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
